biquad_cascade_sched: RTL
=========================

Name: biquad_cascade_sched

Overview:
Scheduler that time-multiplexes one external 16x16 MAC accumulator across N_STAGES cascaded biquad sections for two audio channels (left/right). It sits between the I2S receive path (l_r_clk, sample) and the MAC wrapper. It sequences taps, fetches coefficients, owns per-stage/per-channel history, and saturates and writes back each section's result.

Parameters:
N_STAGES, 2, number of cascaded biquad sections (1..8)
MAC_LAT, 2, cycles from last mac_ce cycle until mac_result is valid

Ports:
clk  in  1  high-speed system clock
reset  in  1  synchronous active-low reset
l_r_clk  in  1  I2S word select; each edge is a new sample (level after edge: 0=left, 1=right)
sample_in  in  16  signed Q2.14 input sample
bypass  in  1  sampled at accepted edge; 1 = pass sample through unfiltered
coef_stage  out  max(1,clog2(N_STAGES))  stage index for coefficient fetch
coef_tap  out  3  0=b0 1=b1 2=b2 3=a1 4=a2
coef_in  in  16  signed Q2.14 coefficient, combinational from coef_stage/coef_tap
mac_a  out  16  coefficient operand
mac_b  out  16  data operand
mac_ce  out  1  MAC accumulate enable
mac_clr_n  out  1  active-low synchronous accumulator clear
mac_result  in  32  Q4.28 accumulator
out_left  out  16  latest left output
out_right  out  16  latest right output
out_valid  out  1  one-cycle pulse when out_left or out_right updates
out_chan  out  1  channel of the last update
busy  out  1  high in every state except IDLE
overrun  out  1  sticky; edge arrived while busy

Behaviour:
- Synchronize l_r_clk through two flops. l_r_edge = d1 ^ d2. Channel = d1.
- Reset (reset=0): state IDLE, all history and outputs 0, out_valid=0, overrun=0, mac_ce=0, mac_clr_n=0. Reset mid-sequence aborts the sequence with no partial writeback.
- History: x1, x2, y1, y2 per stage per channel. x_cur is the input to the current stage.
- IDLE: on l_r_edge, latch sample_in to x_cur, channel, and bypass. Drive mac_clr_n=0 that cycle. Go to MULT with stage=0 and tap=0, or to OUT with y=sample_in if bypass.
- MULT (5 cycles, tap 0..4, mac_ce=1):
  - tap 0: mac_a=coef_in, mac_b=x_cur
  - tap 1: mac_a=coef_in, mac_b=x1
  - tap 2: mac_a=coef_in, mac_b=x2
  - tap 3: mac_a=-coef_in, mac_b=y1
  - tap 4: mac_a=-coef_in, mac_b=y2
  - Negating -32768 gives +32767.
  - coef_stage/coef_tap equal the current stage/tap in every MULT cycle.
- WAIT: MAC_LAT cycles, mac_ce=0.
- WB (1 cycle):
  - y = mac_result[29:14] if mac_result[31:29] are all equal. Otherwise saturate to 0x7FFF (positive) or 0x8000 (negative).
  - Update this stage/channel: x2<=x1, x1<=x_cur, y2<=y1, y1<=y. Then x_cur<=y.
  - mac_clr_n=0.
  - If stage<N_STAGES-1: stage++, go to MULT. Else go to OUT.
- OUT: load out_left or out_right per channel, set out_chan. Register out_valid=1 so it is high in the first cycle the new value is visible. Go to IDLE.
- mac_ce=0 and mac_a=mac_b=0 outside MULT. mac_clr_n=1 except where stated above.
- Latency: from the l_r_edge cycle to out_valid = N_STAGES*(6+MAC_LAT)+2, which is 18 at defaults. Bypass latency is 2.
- l_r_edge while busy: set overrun (cleared only by reset), drop the sample, leave history untouched. An edge in the OUT→IDLE cycle counts as busy. An edge in the IDLE cycle is accepted.
- The other channel's outputs and history never change during a sequence.

Test Plan:
- Identity: b0=0x4000, others 0, N_STAGES=2, left sample 0x1234 → out_left=0x1234, out_valid exactly 18 cycles after the detected edge, out_right stays 0.
- Impulse: stage0 b0=0x4000, a1=0xE000 (-0.5); stage1 identity; left impulse 0x2000 then zeros → left outputs 0x2000, 0x1000, 0x0800, 0x0400.
- Saturation: b0=b1=0x7FFF, two consecutive left samples 0x7FFF → second output 0x7FFF; with sample 0x8000 repeated → 0x8000.
- Channel isolation: alternate left=0x1000 and right=0x0000 with b1=0x4000 → right output stays 0 and left history is unaffected by right samples; out_chan matches each sample.
- Overrun: second l_r edge 5 cycles after the first → overrun=1, one out_valid only, history reflects only the first sample. Bypass=1 with sample 0x5555 → out=0x5555, 2-cycle latency.
- Reset mid-MULT: assert reset at stage 1 tap 2 → after release all outputs, history and overrun are 0, and the next sample filters as from a cold start.

Source files
------------

// File: rtl/biquad_cascade_sched.sv
// Time-multiplexes one external MAC across N_STAGES biquad sections for a stereo
// I2S stream; owns per-stage/per-channel history and saturating writeback.
module biquad_cascade_sched #(
  parameter int N_STAGES = 2,
  parameter int MAC_LAT  = 2,
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          l_r_clk,
  input  logic [15:0]   sample_in,
  input  logic          bypass,
  output logic [SW-1:0] coef_stage,
  output logic [2:0]    coef_tap,
  input  logic [15:0]   coef_in,
  output logic [15:0]   mac_a,
  output logic [15:0]   mac_b,
  output logic          mac_ce,
  output logic          mac_clr_n,
  input  logic [31:0]   mac_result,
  output logic [15:0]   out_left,
  output logic [15:0]   out_right,
  output logic          out_valid,
  output logic          out_chan,
  output logic          busy,
  output logic          overrun
);

  localparam int WW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);
  localparam logic [WW-1:0] LAST_WAIT  = WW'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, MULT, WAIT, WB, OUT} state_t;
  state_t state, state_nx;

  logic          lr_d1, lr_d2, lr_edge;
  logic [SW-1:0] stage;
  logic [2:0]    tap;
  logic [WW-1:0] wcnt;
  logic          chan;
  logic [15:0]   x_cur;
  logic [15:0]   x1 [2][N_STAGES];
  logic [15:0]   x2 [2][N_STAGES];
  logic [15:0]   y1 [2][N_STAGES];
  logic [15:0]   y2 [2][N_STAGES];
  logic [15:0]   y_sat;
  logic [15:0]   coef_neg;
  logic          unused_frac;

  // Synchronizer is left free-running through reset so a held word-select
  // level never looks like a fresh edge when reset releases.
  always_ff @(posedge clk) begin
    lr_d1 <= l_r_clk;
    lr_d2 <= lr_d1;
  end

  assign lr_edge     = lr_d1 ^ lr_d2;
  assign busy        = (state != IDLE);
  assign unused_frac = ^mac_result[13:0];

  always_comb begin
    coef_neg = (coef_in == 16'h8000) ? 16'h7FFF : (~coef_in + 16'd1);
    if (mac_result[31:29] == 3'b000 || mac_result[31:29] == 3'b111)
      y_sat = mac_result[29:14];
    else
      y_sat = mac_result[31] ? 16'h8000 : 16'h7FFF;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mac_ce     = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    mac_clr_n  = 1'b1;
    coef_stage = stage;
    coef_tap   = tap;
    case (state)
      IDLE: begin
        if (lr_edge) begin
          mac_clr_n = 1'b0;
          state_nx  = bypass ? OUT : MULT;
        end
      end
      MULT: begin
        mac_ce = 1'b1;
        case (tap)
          3'd0:    begin mac_a = coef_in;  mac_b = x_cur;             end
          3'd1:    begin mac_a = coef_in;  mac_b = x1[chan][stage];   end
          3'd2:    begin mac_a = coef_in;  mac_b = x2[chan][stage];   end
          3'd3:    begin mac_a = coef_neg; mac_b = y1[chan][stage];   end
          default: begin mac_a = coef_neg; mac_b = y2[chan][stage];   end
        endcase
        if (tap == 3'd4) state_nx = (MAC_LAT > 0) ? WAIT : WB;
      end
      WAIT: begin
        if (wcnt == LAST_WAIT) state_nx = WB;
      end
      WB: begin
        mac_clr_n = 1'b0;
        state_nx  = (stage == LAST_STAGE) ? OUT : MULT;
      end
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Reset forces the MAC quiet and cleared even before the state register catches up.
    if (!reset) begin
      mac_ce    = 1'b0;
      mac_a     = '0;
      mac_b     = '0;
      mac_clr_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage     <= '0;
      tap       <= '0;
      wcnt      <= '0;
      chan      <= 1'b0;
      x_cur     <= '0;
      x1        <= '{default: '0};
      x2        <= '{default: '0};
      y1        <= '{default: '0};
      y2        <= '{default: '0};
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      out_chan  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (lr_edge && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (lr_edge) begin
            x_cur <= sample_in;
            chan  <= lr_d1;
            stage <= '0;
            tap   <= '0;
          end
        end
        MULT: begin
          tap  <= (tap == 3'd4) ? 3'd0 : tap + 3'd1;
          wcnt <= '0;
        end
        WAIT: wcnt <= wcnt + 1'b1;
        WB: begin
          x2[chan][stage] <= x1[chan][stage];
          x1[chan][stage] <= x_cur;
          y2[chan][stage] <= y1[chan][stage];
          y1[chan][stage] <= y_sat;
          x_cur           <= y_sat;
          if (stage != LAST_STAGE) stage <= stage + 1'b1;
        end
        OUT: begin
          if (chan) out_right <= x_cur;
          else      out_left  <= x_cur;
          out_chan  <= chan;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
